// File: rtl/common_vl_pack.sv
// Shared definitions for the receive_send word path and the frame packer.
// Mirrored on the VHDL side by common_vh_pack.
package common_vl_pack;
    localparam int vl_word_size = 3;
    typedef logic [vl_word_size:0] vl_arr;

    localparam int FRAME_WORDS_DEF = 4;
    localparam int FIFO_DEPTH_DEF  = 4;

    typedef logic [FRAME_WORDS_DEF*(vl_word_size+1)-1:0] frame_t;
endpackage

// File: rtl/frame_fifo.sv
// Small frame FIFO: synchronous write/read, full/empty/fill.
// The read data is the registered head entry, forced to zero while empty.
module frame_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        do_push = push & (~full | do_pop);
        fill    = cnt;
        rdata   = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/frame_packer.sv
// Packs FRAME_WORDS receive_send words into frames queued in frame_fifo.
// Optional per-frame even parity is enabled by defining FRAME_PAR_EN.
module frame_packer
    import common_vl_pack::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [vl_word_size:0]                   in_word,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [FRAME_WORDS*(vl_word_size+1)-1:0] out_frame,
    output logic                                    out_par,
    output logic [$clog2(FIFO_DEPTH):0]             fill,
    output logic                                    ovf,
    input  logic                                    ovf_clr
);
    localparam int W  = vl_word_size + 1;
    localparam int FW = FRAME_WORDS * W;
    localparam int CW = $clog2(FRAME_WORDS);

    logic [CW-1:0] cnt;
    logic [FW-1:0] acc;
    logic [FW-1:0] frame_next;
    logic          last;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic          empty;

    // Output handshake: a frame transfers on a cycle where out_valid & out_ready are
    // both high; out_frame/out_par hold steady while out_valid=1 and out_ready=0.
    // The input side has no ready: words the packer cannot store are dropped into ovf.
    always_comb begin
        last       = (cnt == CW'(FRAME_WORDS-1));
        pop        = out_valid & out_ready;
        push       = in_valid & last & (~full | pop);
        drop       = in_valid & last & full & ~pop;
        frame_next = acc;
        frame_next[int'(cnt)*W +: W] = in_word;
        out_valid  = ~empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            // A dropped completing word leaves count and accumulator intact for a retry.
            if (in_valid && !drop) begin
                if (last) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= frame_next;
                end
            end
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef FRAME_PAR_EN
    logic [FW:0] fifo_rd;

    frame_fifo #(.WIDTH(FW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({^frame_next, frame_next}),
        .pop   (pop),
        .rdata (fifo_rd),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    assign out_frame = fifo_rd[FW-1:0];
    assign out_par   = fifo_rd[FW];
`else
    frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (frame_next),
        .pop   (pop),
        .rdata (out_frame),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    assign out_par = 1'b0;
`endif
endmodule

// File: tb/tb_frame_packer.sv
// Directed, table-driven bench for frame_packer (4 words of 4 bits, 4-deep FIFO).
module tb_frame_packer;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_word;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_frame;
    logic        out_par;
    logic [2:0]  fill;
    logic        ovf;
    logic        ovf_clr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [3:0]  w;
        logic        r;
        logic        c;
        logic        ev;
        logic [15:0] ef;
        int          efill;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    frame_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .out_par   (out_par),
        .fill      (fill),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic exp_par(input logic [15:0] f);
`ifdef FRAME_PAR_EN
        return ^f;
`else
        return 1'b0 & f[0];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] w, input logic r, input logic c,
                       input logic ev, input logic [15:0] ef, input int efill, input logic eovf);
        vecs.push_back('{v, w, r, c, ev, ef, efill, eovf});
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] ef,
                              input int efill, input logic eovf);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_frame"}, 32'(out_frame), 32'(ef));
        chk({tag, "_fill"},  32'(fill),      32'(efill));
        chk({tag, "_ovf"},   32'(ovf),       32'(eovf));
        chk({tag, "_par"},   32'(out_par),   32'(exp_par(ef)));
    endtask

    // driver: apply one row for one clock, check #1 after the edge
    task automatic run_row(input vec_t x, input string tag);
        in_valid  = x.v;
        in_word   = x.w;
        out_ready = x.r;
        ovf_clr   = x.c;
        @(posedge clk);
        #1;
        check_outs(tag, x.ev, x.ef, x.efill, x.eovf);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 16'h0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // first frame 1,2,3,4
        add(1, 4'h1, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h2, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h3, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h4, 0, 0, 1, 16'h4321, 1, 0);
        // frames 8765, cba9, 1fed fill the FIFO with no consumer
        for (int i = 5; i <= 16; i++)
            add(1, (i == 16) ? 4'h1 : 4'(i), 0, 0, 1, 16'h4321, i / 4, 0);
        // fifth frame: first three words kept, completing word dropped
        add(1, 4'h2, 0, 0, 1, 16'h4321, 4, 0);
        add(1, 4'h3, 0, 0, 1, 16'h4321, 4, 0);
        add(1, 4'h4, 0, 0, 1, 16'h4321, 4, 0);
        add(1, 4'h5, 0, 0, 1, 16'h4321, 4, 1);
        // retry with a pop in the same cycle: push 6432, fill unchanged
        add(1, 4'h6, 1, 0, 1, 16'h8765, 4, 1);
        // stalled head, in_word undriven
        for (int i = 0; i < 10; i++)
            add(0, 4'bxxxx, 0, 0, 1, 16'h8765, 4, 1);
        add(0, 4'h0, 1, 0, 1, 16'hcba9, 3, 1);
        // clear alone
        add(0, 4'h0, 0, 1, 1, 16'hcba9, 3, 0);
        // refill to full with a987
        add(1, 4'h7, 0, 0, 1, 16'hcba9, 3, 0);
        add(1, 4'h8, 0, 0, 1, 16'hcba9, 3, 0);
        add(1, 4'h9, 0, 0, 1, 16'hcba9, 3, 0);
        add(1, 4'ha, 0, 0, 1, 16'hcba9, 4, 0);
        // overflow together with clear: set wins
        add(1, 4'h1, 0, 0, 1, 16'hcba9, 4, 0);
        add(1, 4'h1, 0, 0, 1, 16'hcba9, 4, 0);
        add(1, 4'h1, 0, 0, 1, 16'hcba9, 4, 0);
        add(1, 4'h2, 0, 1, 1, 16'hcba9, 4, 1);
        add(0, 4'h0, 0, 1, 1, 16'hcba9, 4, 0);
        // drain
        add(0, 4'h0, 1, 0, 1, 16'h1fed, 3, 0);
        add(0, 4'h0, 1, 0, 1, 16'h6432, 2, 0);
        add(0, 4'h0, 1, 0, 1, 16'ha987, 1, 0);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 0, 0);
        // retried completion after drain uses the kept 1,1,1
        add(1, 4'h3, 0, 0, 1, 16'h3111, 1, 0);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 0, 0);
        // parity frames 0001 and 0003
        add(1, 4'h1, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 1, 16'h0001, 1, 0);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h3, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 4'h0, 0, 0, 1, 16'h0003, 1, 0);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i], $sformatf("row%0d", i));

        // reset mid-frame with a queued frame
        run_row('{1, 4'h1, 0, 0, 0, 16'h0000, 0, 0}, "rst_a");
        run_row('{1, 4'h2, 0, 0, 0, 16'h0000, 0, 0}, "rst_b");
        run_row('{1, 4'h3, 0, 0, 0, 16'h0000, 0, 0}, "rst_c");
        run_row('{1, 4'h4, 0, 0, 1, 16'h4321, 1, 0}, "rst_d");
        run_row('{1, 4'h5, 0, 0, 1, 16'h4321, 1, 0}, "rst_e");
        run_row('{1, 4'h6, 0, 0, 1, 16'h4321, 1, 0}, "rst_f");
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 16'h0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_row('{1, 4'h5, 0, 0, 0, 16'h0000, 0, 0}, "post_a");
        run_row('{1, 4'h6, 0, 0, 0, 16'h0000, 0, 0}, "post_b");
        run_row('{1, 4'h7, 0, 0, 0, 16'h0000, 0, 0}, "post_c");
        run_row('{1, 4'h8, 0, 0, 1, 16'h8765, 1, 0}, "post_d");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
